// File: rtl/mem_access_stage_pkg.sv
// Shared RV32I load/store encodings and MEM-stage FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage_lsu_align.sv
// Byte-lane steering: load extraction/extension, store replication/enables, alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_be
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B: begin
        store_be    = 4'b0001 << addr_lo;
        store_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        store_be    = 4'b0011 << addr_lo;
        store_wdata = {2{wdata[15:0]}};
      end
      F3_W: begin
        store_be    = 4'b1111;
        store_wdata = wdata;
      end
      default: begin
        store_be    = '0;
        store_wdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores on the dmem bus, stalls upstream while waiting.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] result_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  mem_access_stage_if.master dmem,
  output logic        stall_out,
  output logic [31:0] result_out,
  output logic [31:0] read_data_out,
  output logic        mem_to_reg_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  state;
  logic [CW-1:0] cnt;

  logic [31:0] load_data;
  logic [31:0] store_wdata;
  logic [3:0]  store_be;
  logic        mis;

  logic mem_op, f3_ok, illegal, go, timeout, req, stall, complete, mis_flag;

  lsu_align u_align (
    .addr_lo     (result_in[1:0]),
    .funct3      (funct3_in),
    .rdata       (dmem.dmem_rdata),
    .wdata       (store_data_in),
    .load_data   (load_data),
    .misaligned  (mis),
    .store_wdata (store_wdata),
    .store_be    (store_be)
  );

  always_comb begin
    mem_op   = valid_in & (mem_read_in ^ mem_write_in);
    f3_ok    = mem_read_in ? (funct3_in inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                           : (funct3_in inside {F3_B, F3_H, F3_W});
    illegal  = valid_in & ((mem_read_in & mem_write_in) | (mem_op & ~f3_ok));
    go       = mem_op & f3_ok & ~mis;
    mis_flag = (state == IDLE) & mem_op & f3_ok & mis;
    // Timeout fires on the cycle that would bring the count to TIMEOUT_CYCLES; a same-cycle ack wins.
    timeout  = (state == WAIT) & ~dmem.dmem_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));
    req      = (state == IDLE) ? go : ~timeout;
    stall    = req & ~dmem.dmem_ack;
    complete = req & dmem.dmem_ack;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (go && !dmem.dmem_ack) begin
          state <= WAIT;
          cnt   <= CW'(1);
        end
        WAIT: if (dmem.dmem_ack || timeout) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    dmem.dmem_req   = rst & req;
    dmem.dmem_we    = rst & mem_write_in;
    dmem.dmem_addr  = rst ? ADDR_W'({result_in[31:2], 2'b00}) : '0;
    dmem.dmem_wdata = (rst && mem_write_in) ? store_wdata : '0;
    dmem.dmem_be    = (rst && req && mem_write_in) ? store_be : '0;
    stall_out       = rst & stall;
    result_out      = rst ? result_in : '0;
    read_data_out   = (rst && complete && mem_read_in) ? load_data : '0;
    mem_to_reg_out  = rst & mem_to_reg_in;
    rd_out          = rst ? rd_in : '0;
    reg_write_out   = rst & reg_write_in & valid_in & ~stall & ~mis_flag & ~timeout & ~illegal;
    misaligned_out  = rst & mis_flag;
    bus_err_out     = rst & timeout;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] result_in;
  logic [31:0] store_data_in;
  logic [2:0]  funct3_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall_out;
  logic [31:0] result_out;
  logic [31:0] read_data_out;
  logic        mem_to_reg_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        misaligned_out;
  logic        bus_err_out;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .result_in      (result_in),
    .store_data_in  (store_data_in),
    .funct3_in      (funct3_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
    .dmem           (bus.master),
    .stall_out      (stall_out),
    .result_out     (result_out),
    .read_data_out  (read_data_out),
    .mem_to_reg_out (mem_to_reg_out),
    .rd_out         (rd_out),
    .reg_write_out  (reg_write_out),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic set_instr(input logic v, input logic [31:0] addr, input logic [2:0] f3,
                           input logic rd_en, input logic wr_en, input logic rw,
                           input logic [4:0] rd, input logic [31:0] sdata);
    valid_in      = v;
    result_in     = addr;
    funct3_in     = f3;
    mem_read_in   = rd_en;
    mem_write_in  = wr_en;
    mem_to_reg_in = rd_en;
    reg_write_in  = rw;
    rd_in         = rd;
    store_data_in = sdata;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    set_instr(1'b1, 32'h100, F3_W, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    #2;
    total++;
    if ({bus.dmem_req, stall_out, reg_write_out, result_out, read_data_out, rd_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b stall=%b rw=%b res=%h rdata=%h rd=%0d, want all 0",
               bus.dmem_req, stall_out, reg_write_out, result_out, read_data_out, rd_out);
    end
    @(negedge clk);
    rst = 1'b1;
    set_instr(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_lw_zero_wait;
    @(negedge clk);
    set_instr(1'b1, 32'h100, F3_W, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
    bus.dmem_rdata = 32'hDEAD_BEEF; bus.dmem_ack = 1'b1;
    #2;
    total++;
    if (read_data_out !== 32'hDEAD_BEEF || reg_write_out !== 1'b1 || rd_out !== 5'd5 ||
        stall_out !== 1'b0 || bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h100) begin
      bad++;
      $display("FAIL lw_zero_wait: rdata=%h rw=%b rd=%0d stall=%b req=%b addr=%h, want deadbeef 1 5 0 1 100",
               read_data_out, reg_write_out, rd_out, stall_out, bus.dmem_req, bus.dmem_addr);
    end
  endtask

  task automatic test_byte_wait(input logic [2:0] f3, input logic [31:0] exp);
    @(negedge clk);
    set_instr(1'b1, 32'h103, f3, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0);
    bus.dmem_rdata = 32'h8011_2233; bus.dmem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      total++;
      if (stall_out !== 1'b1 || reg_write_out !== 1'b0 || read_data_out !== 32'h0) begin
        bad++;
        $display("FAIL byte_wait_stall c=%0d: stall=%b rw=%b rdata=%h, want 1 0 0",
                 c, stall_out, reg_write_out, read_data_out);
      end
      @(negedge clk);
    end
    bus.dmem_ack = 1'b1;
    #2;
    total++;
    if (read_data_out !== exp || stall_out !== 1'b0 || reg_write_out !== 1'b1) begin
      bad++;
      $display("FAIL byte_wait_ack f3=%b: rdata=%h stall=%b rw=%b, want %h 0 1",
               f3, read_data_out, stall_out, reg_write_out, exp);
    end
  endtask

  task automatic test_load_lanes;
    logic [2:0]  f3s  [5] = '{F3_H, F3_HU, F3_B, F3_H, F3_BU};
    logic [31:0] adrs [5] = '{32'h42, 32'h42, 32'h41, 32'h40, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFF_8011, 32'h0000_8011, 32'h0000_0022,
                              32'h0000_2233, 32'h0000_0033};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_instr(1'b1, adrs[i], f3s[i], 1'b1, 1'b0, 1'b1, 5'd1, 32'h0);
      bus.dmem_rdata = 32'h8011_2233; bus.dmem_ack = 1'b1;
      #2;
      total++;
      if (read_data_out !== exps[i] || reg_write_out !== 1'b1) begin
        bad++;
        $display("FAIL load_lane %0d: rdata=%h rw=%b, want %h 1", i, read_data_out, reg_write_out, exps[i]);
      end
    end
  endtask

  task automatic test_stores;
    @(negedge clk);
    set_instr(1'b1, 32'h202, F3_H, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_ABCD);
    bus.dmem_ack = 1'b1;
    #2;
    total++;
    if (bus.dmem_addr !== 32'h200 || bus.dmem_be !== 4'b1100 || bus.dmem_wdata !== 32'hABCD_ABCD ||
        bus.dmem_we !== 1'b1 || bus.dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL sh_upper: addr=%h be=%b wdata=%h we=%b req=%b, want 200 1100 abcdabcd 1 1",
               bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.dmem_we, bus.dmem_req);
    end
    @(negedge clk);
    set_instr(1'b1, 32'h205, F3_B, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234_565A);
    #2;
    total++;
    if (bus.dmem_addr !== 32'h204 || bus.dmem_be !== 4'b0010 || bus.dmem_wdata !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL sb_lane1: addr=%h be=%b wdata=%h, want 204 0010 5a5a5a5a",
               bus.dmem_addr, bus.dmem_be, bus.dmem_wdata);
    end
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    set_instr(1'b1, 32'h101, F3_W, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0);
    bus.dmem_ack = 1'b0;
    #2;
    total++;
    if (misaligned_out !== 1'b1 || bus.dmem_req !== 1'b0 || reg_write_out !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL misaligned_lw: mis=%b req=%b rw=%b stall=%b, want 1 0 0 0",
               misaligned_out, bus.dmem_req, reg_write_out, stall_out);
    end
    @(negedge clk);
    set_instr(1'b1, 32'h103, F3_H, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0);
    #2;
    total++;
    if (misaligned_out !== 1'b1 || bus.dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL misaligned_lh: mis=%b req=%b, want 1 0", misaligned_out, bus.dmem_req);
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    set_instr(1'b1, 32'h100, F3_W, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0);
    bus.dmem_ack = 1'b0;
    #2;
    total++;
    if (bus.dmem_req !== 1'b0 || reg_write_out !== 1'b0 || misaligned_out !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL rd_and_wr: req=%b rw=%b mis=%b stall=%b, want 0 0 0 0",
               bus.dmem_req, reg_write_out, misaligned_out, stall_out);
    end
    @(negedge clk);
    set_instr(1'b1, 32'h100, 3'b011, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0);
    #2;
    total++;
    if (bus.dmem_req !== 1'b0 || reg_write_out !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL reserved_f3: req=%b rw=%b stall=%b, want 0 0 0", bus.dmem_req, reg_write_out, stall_out);
    end
  endtask

  task automatic test_timeout;
    @(negedge clk);
    set_instr(1'b1, 32'h300, F3_W, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1111_2222);
    bus.dmem_ack = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #2;
      total++;
      if (stall_out !== 1'b1 || bus_err_out !== 1'b0 || bus.dmem_req !== 1'b1) begin
        bad++;
        $display("FAIL timeout_wait cycle=%0d: stall=%b err=%b req=%b, want 1 0 1",
                 c, stall_out, bus_err_out, bus.dmem_req);
      end
      @(negedge clk);
    end
    #2;
    total++;
    if (bus_err_out !== 1'b1 || bus.dmem_req !== 1'b0 || stall_out !== 1'b0 || reg_write_out !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err: err=%b req=%b stall=%b rw=%b, want 1 0 0 0",
               bus_err_out, bus.dmem_req, stall_out, reg_write_out);
    end
    @(negedge clk);
    set_instr(1'b1, 32'h100, F3_W, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0);
    bus.dmem_rdata = 32'h0BAD_F00D; bus.dmem_ack = 1'b1;
    #2;
    total++;
    if (bus_err_out !== 1'b0 || stall_out !== 1'b0 || read_data_out !== 32'h0BAD_F00D || reg_write_out !== 1'b1) begin
      bad++;
      $display("FAIL timeout_idle: err=%b stall=%b rdata=%h rw=%b, want 0 0 0badf00d 1",
               bus_err_out, stall_out, read_data_out, reg_write_out);
    end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    set_instr(1'b1, 32'h104, F3_W, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0);
    bus.dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    total++;
    if ({bus.dmem_req, stall_out, reg_write_out, result_out, rd_out, bus_err_out} !== '0) begin
      bad++;
      $display("FAIL reset_in_wait: req=%b stall=%b rw=%b res=%h rd=%0d err=%b, want all 0",
               bus.dmem_req, stall_out, reg_write_out, result_out, rd_out, bus_err_out);
    end
    @(negedge clk);
    rst = 1'b1;
    set_instr(1'b1, 32'h1234_5678, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0);
    #2;
    total++;
    if (result_out !== 32'h1234_5678 || reg_write_out !== 1'b1 || rd_out !== 5'd7 ||
        stall_out !== 1'b0 || bus.dmem_req !== 1'b0 || read_data_out !== 32'h0) begin
      bad++;
      $display("FAIL alu_after_reset: res=%h rw=%b rd=%0d stall=%b req=%b rdata=%h, want 12345678 1 7 0 0 0",
               result_out, reg_write_out, rd_out, stall_out, bus.dmem_req, read_data_out);
    end
  endtask

  initial begin
    rst = 1'b0;
    set_instr(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    test_reset;
    test_lw_zero_wait;
    test_byte_wait(F3_B, 32'hFFFF_FF80);
    test_byte_wait(F3_BU, 32'h0000_0080);
    test_load_lanes;
    test_stores;
    test_misaligned;
    test_illegal;
    test_timeout;
    test_reset_in_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage between the EX/MEM register and the MEM/WB register.
- Performs RV32I loads and stores over a req/ack data-memory bus.
- Formats load data with byte-lane extraction and sign/zero extension.
- Stalls upstream stages while an access is outstanding, and drives the *_in_mem_wb inputs of the MEM/WB register.
- Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before a bus error is declared (minimum 2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- valid_in  in  1  EX/MEM holds a live instruction.
- result_in  in  32  ALU result; this is the byte address for loads and stores.
- store_data_in  in  32  rs2 value for stores.
- funct3_in  in  3  load/store size and sign encoding.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- mem_to_reg_in  in  1  writeback selects memory data.
- rd_in  in  5  destination register.
- reg_write_in  in  1  instruction writes the register file.
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read word, valid when dmem_ack = 1.
- dmem_ack  in  1  completes the current request in the same cycle.
- stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- result_out  out  32  copy of result_in, passed to MEM/WB.
- read_data_out  out  32  formatted load data.
- mem_to_reg_out  out  1  copy of mem_to_reg_in.
- rd_out  out  5  copy of rd_in.
- reg_write_out  out  1  gated write enable.
- misaligned_out  out  1  one-cycle flag for a misaligned access.
- bus_err_out  out  1  one-cycle flag for a bus timeout.

Behaviour:
- **Reset**
  - While rst = 0, all outputs are driven to 0.
  - On the next clk edge: state ← IDLE, timeout counter ← 0.
  - Reset asserted in WAIT abandons the access; no writeback occurs.
- **Memory op**
  - mem_op = valid_in & (mem_read_in ^ mem_write_in).
  - mem_read_in and mem_write_in both 1: the instruction is a no-op with reg_write_out = 0, no request and no flag.
- **Alignment**
  - Halfword with addr[0] = 1 is misaligned.
  - Word with addr[1:0] ≠ 00 is misaligned.
  - On a misaligned access: misaligned_out = 1 for that cycle, no request, reg_write_out = 0, no stall.
- **FSM states**
  - IDLE:
    - dmem_req = mem_op & aligned (combinational).
    - If dmem_ack is 1 in the same cycle: complete with zero stall.
    - Otherwise: stall_out = 1 and move to WAIT; the counter starts at 1.
  - WAIT:
    - dmem_req = 1 and stall_out = 1.
    - Upstream holds its inputs stable because of the stall.
    - Counter increments each cycle.
    - On dmem_ack: stall_out = 0, complete, go to IDLE, clear the counter.
    - If the counter reaches TIMEOUT_CYCLES without an ack: bus_err_out = 1 for that cycle, dmem_req drops, stall_out = 0, reg_write_out = 0, go to IDLE.
    - An ack arriving in the same cycle as the timeout wins: the access completes normally.
- **Bubble rule**
  - reg_write_out = reg_write_in & valid_in & ~stall_out & ~misaligned & ~bus_err & ~illegal.
  - MEM/WB therefore latches a bubble on every stall cycle.
- **Pass-through**
  - result_out, mem_to_reg_out and rd_out are combinational copies of their inputs.
- **Loads**
  - funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - The lane is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - read_data_out is valid in the ack cycle; otherwise it is 0.
- **Stores**
  - funct3 000 SB, 001 SH, 010 SW.
  - SB: be = 0001 << addr[1:0]; data byte replicated ×4.
  - SH: be = 0011 << addr[1:0]; halfword replicated ×2.
  - SW: be = 1111.
  - dmem_we = mem_write_in.
  - Reserved funct3 values are treated as illegal: no-op as above.
- **Other outputs**
  - Non-memory instructions pass through with reg_write_out = reg_write_in & valid_in.
  - No state change for non-memory instructions.
- **Counter width**: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package riscv_pkg holds:
  - funct3 load/store localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - typedef enum logic {IDLE, WAIT} mem_state_t.
- Sub-module lsu_align (purely combinational):
  - Load path: addr[1:0], funct3, rdata → formatted data plus misaligned flag.
  - Store path: addr[1:0], funct3, wdata → dmem_wdata and dmem_be.

Test Plan:
1. **LW, zero-wait**: LW at addr 0x100, dmem_rdata = 0xDEADBEEF, ack in the same cycle → read_data_out = 0xDEADBEEF, reg_write_out = 1, rd_out as given, stall_out = 0.
2. **LB, sign-extended, 2 wait states**: LB at addr 0x103, rdata = 0x80112233, ack after 2 wait cycles → stall_out = 1 for 2 cycles with reg_write_out = 0; in the ack cycle read_data_out = 0xFFFFFF80. Repeat as LBU → 0x00000080.
3. **SH, upper half**: SH at addr 0x202, store_data = 0x0000ABCD → dmem_addr = 0x200, dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_we = 1.
4. **Misaligned LW**: LW at addr 0x101 → misaligned_out = 1 for one cycle, dmem_req = 0, reg_write_out = 0, stall_out = 0.
5. **Timeout**: SW with ack held at 0 and TIMEOUT_CYCLES = 16 → stall for 15 cycles; bus_err_out = 1 in cycle 16 with req and stall deasserted; then IDLE.
6. **Reset in WAIT**: rst driven 0 in the 3rd wait cycle → all outputs 0; after rst returns to 1, an ALU instruction with result 0x12345678 passes through with reg_write_out = 1.
